uart_tx_cfg: RTL and testbench

- Parametrised successor to the fixed 8N1 UART transmitter in the bring-up UART path.
- Serialises one parallel word per accepted write onto `tx`.
- Configurable data width, baud divisor, parity and stop-bit count.
- Single write-enable / ready handshake; optional small input FIFO so software-side logic can queue bytes while a frame is on the line.

---
 rtl/uart_tx_cfg.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: data width, baud divisor, parity and stop-bit count.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry write queue ahead of the serialiser.
module uart_tx_cfg #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 write_en,
    output logic                 rdy,
    output logic                 tx,
    output logic                 busy
);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t               state_reg;
    logic [BAUD_W-1:0]    baud_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic                 stop_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 tx_reg;
    logic                 busy_reg;

    logic                 baud_wrap;
    logic                 last_stop;
    logic                 take_ok;
    logic                 word_avail;
    logic                 load;
    logic [DATA_BITS-1:0] word_in;
    logic                 parity_next;

    assign baud_wrap   = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_stop   = (state_reg == STOP) && baud_wrap && (stop_reg == 1'(STOP_BITS - 1));
    assign take_ok     = (state_reg == IDLE) || last_stop;
    assign load        = take_ok && word_avail;
    assign parity_next = (PARITY == 2) ? ^word_in : ~^word_in;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_reg;
    logic [PTR_W:0]       rd_ptr_reg;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    // An empty queue is bypassed so a lone write starts a frame as fast as without the FIFO.
    assign word_avail = !fifo_empty || write_en;
    assign word_in    = fifo_empty ? data : fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign pop        = take_ok && !fifo_empty;
    assign push       = write_en && !fifo_full && !(fifo_empty && take_ok);
    assign rdy        = !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end
`else
    logic rdy_reg;

    assign word_avail = write_en && rdy_reg;
    assign word_in    = data;
    assign rdy        = rdy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_reg <= 1'b1;
        end else if (load) begin
            rdy_reg <= 1'b0;
        end else if (last_stop) begin
            rdy_reg <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
        end else if (state_reg == IDLE) begin
            tx_reg <= 1'b1;
            if (load) begin
                state_reg  <= START;
                baud_reg   <= '0;
                stop_reg   <= 1'b0;
                shift_reg  <= word_in;
                parity_reg <= parity_next;
                tx_reg     <= 1'b0;
                busy_reg   <= 1'b1;
            end
        end else begin
            baud_reg <= baud_wrap ? '0 : baud_reg + 1'b1;
            if (baud_wrap) begin
                case (state_reg)
                    START: begin
                        state_reg <= DATA;
                        bit_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state_reg <= PARITY_BIT;
                                tx_reg    <= parity_reg;
                            end else begin
                                state_reg <= STOP;
                                stop_reg  <= 1'b0;
                                tx_reg    <= 1'b1;
                            end
                        end else begin
                            bit_reg   <= bit_reg + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end
                    PARITY_BIT: begin
                        state_reg <= STOP;
                        stop_reg  <= 1'b0;
                        tx_reg    <= 1'b1;
                    end
                    STOP: begin
                        if (stop_reg == 1'(STOP_BITS - 1)) begin
                            // A pending word goes straight into its start bit with no idle gap.
                            if (load) begin
                                state_reg  <= START;
                                stop_reg   <= 1'b0;
                                shift_reg  <= word_in;
                                parity_reg <= parity_next;
                                tx_reg     <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end else begin
                            stop_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: three parameter sets, plus the FIFO build.
module tb_uart_tx_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic       rst0, we0, rdy0, tx0, busy0;
    logic [7:0] data0;
    logic       rst1, we1, rdy1, tx1, busy1;
    logic [7:0] data1;
    logic       rst2, we2, rdy2, tx2, busy2;
    logic [6:0] data2;

    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
        .clk(clk), .rst(rst0), .data(data0), .write_en(we0), .rdy(rdy0), .tx(tx0), .busy(busy0));
    uart_tx_cfg #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .rst(rst1), .data(data1), .write_en(we1), .rdy(rdy1), .tx(tx1), .busy(busy1));
    uart_tx_cfg #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) d2 (
        .clk(clk), .rst(rst2), .data(data2), .write_en(we2), .rdy(rdy2), .tx(tx2), .busy(busy2));

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        data0 = '0; data1 = '0; data2 = '0;
        repeat (2) @(negedge clk);
        total_cnt += 6;
        if (tx0 !== 1'b1)   $display("FAIL reset_tx0: got %b want 1", tx0);   else pass_cnt++;
        if (rdy0 !== 1'b1)  $display("FAIL reset_rdy0: got %b want 1", rdy0); else pass_cnt++;
        if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b want 0", busy0); else pass_cnt++;
        if (tx1 !== 1'b1)   $display("FAIL reset_tx1: got %b want 1", tx1);   else pass_cnt++;
        if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b want 0", busy1); else pass_cnt++;
        if (tx2 !== 1'b1)   $display("FAIL reset_tx2: got %b want 1", tx2);   else pass_cnt++;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        $display("reset: done");
    endtask

`ifdef UART_TX_FIFO_EN
    task automatic test_fifo();
        logic [7:0] words [6];
        logic [9:0] frame;
        logic       exp_rdy;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        data0 = words[0];
        we0   = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            frame = {1'b1, words[c / 10], 1'b0};
            total_cnt += 2;
            if (tx0 !== frame[c % 10]) $display("FAIL fifo_tx c=%0d: got %b want %b", c, tx0, frame[c % 10]);
            else pass_cnt++;
            if (busy0 !== 1'b1) $display("FAIL fifo_busy c=%0d: got %b want 1", c, busy0);
            else pass_cnt++;
            if (c < 12) begin
                exp_rdy = (c < 4) || (c == 10);
                total_cnt++;
                if (rdy0 !== exp_rdy) $display("FAIL fifo_rdy c=%0d: got %b want %b", c, rdy0, exp_rdy);
                else pass_cnt++;
            end
            if (c <= 4) data0 = words[c + 1];
            else if (c == 11) we0 = 1'b0;
        end
        @(negedge clk);
        total_cnt += 3;
        if (busy0 !== 1'b0) $display("FAIL fifo_end_busy: got %b want 0", busy0); else pass_cnt++;
        if (tx0 !== 1'b1)   $display("FAIL fifo_end_tx: got %b want 1", tx0);     else pass_cnt++;
        if (rdy0 !== 1'b1)  $display("FAIL fifo_end_rdy: got %b want 1", rdy0);   else pass_cnt++;
        $display("fifo: six queued frames checked");
    endtask
`else
    task automatic test_basic();
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        data0 = 8'h55;
        we0   = 1'b1;
        @(negedge clk);
        we0   = 1'b0;
        data0 = 8'hFF;  // later data must not disturb the frame in flight
        total_cnt += 3;
        if (tx0 !== 1'b0)   $display("FAIL basic_start_tx: got %b want 0", tx0);   else pass_cnt++;
        if (rdy0 !== 1'b0)  $display("FAIL basic_start_rdy: got %b want 0", rdy0); else pass_cnt++;
        if (busy0 !== 1'b1) $display("FAIL basic_start_busy: got %b want 1", busy0); else pass_cnt++;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (tx0 !== frame[i]) $display("FAIL basic_bit%0d: got %b want %b", i, tx0, frame[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rdy0 !== 1'b0) $display("FAIL basic_stop_rdy: got %b want 0", rdy0); else pass_cnt++;
        @(negedge clk);
        total_cnt += 2;
        if (rdy0 !== 1'b1)  $display("FAIL basic_idle_rdy: got %b want 1", rdy0);   else pass_cnt++;
        if (busy0 !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy0); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total_cnt++;
            if (tx0 !== 1'b1) $display("FAIL basic_idle_tx%0d: got %b want 1", i, tx0); else pass_cnt++;
        end
        $display("basic: 8'h55 frame checked");
    endtask

    task automatic test_parity_even();
        logic [10:0] frame;
        frame = {1'b1, 1'b1, 8'h07, 1'b0};
        data1 = 8'h07;
        we1   = 1'b1;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            if (c == 0) we1 = 1'b0;
            total_cnt++;
            if (tx1 !== frame[c / 4]) $display("FAIL even_tx c=%0d: got %b want %b", c, tx1, frame[c / 4]);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt += 2;
        if (busy1 !== 1'b0) $display("FAIL even_end_busy: got %b want 0", busy1); else pass_cnt++;
        if (rdy1 !== 1'b1)  $display("FAIL even_end_rdy: got %b want 1", rdy1);   else pass_cnt++;
        $display("parity_even: 44-cycle frame checked");
    endtask

    task automatic test_odd_two_stop();
        logic [10:0] frame;
        frame = {2'b11, 1'b1, 7'h00, 1'b0};
        data2 = 7'h00;
        we2   = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c == 0) we2 = 1'b0;
            total_cnt += 2;
            if (tx2 !== frame[c]) $display("FAIL odd_tx c=%0d: got %b want %b", c, tx2, frame[c]);
            else pass_cnt++;
            if (rdy2 !== 1'b0) $display("FAIL odd_rdy c=%0d: got %b want 0", c, rdy2);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (rdy2 !== 1'b1) $display("FAIL odd_end_rdy: got %b want 1", rdy2); else pass_cnt++;
        $display("odd_two_stop: 7-bit frame checked");
    endtask

    task automatic test_back_to_back();
        logic [9:0] frame;
        int         pos;
        frame = {1'b1, 8'hA3, 1'b0};
        data0 = 8'hA3;
        we0   = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(negedge clk);
            pos = k % 11;
            if (pos < 10) begin
                total_cnt++;
                if (tx0 !== frame[pos]) $display("FAIL b2b_tx k=%0d: got %b want %b", k, tx0, frame[pos]);
                else pass_cnt++;
            end else begin
                total_cnt += 3;
                if (tx0 !== 1'b1)   $display("FAIL b2b_gap_tx k=%0d: got %b want 1", k, tx0);     else pass_cnt++;
                if (busy0 !== 1'b0) $display("FAIL b2b_gap_busy k=%0d: got %b want 0", k, busy0); else pass_cnt++;
                if (rdy0 !== 1'b1)  $display("FAIL b2b_gap_rdy k=%0d: got %b want 1", k, rdy0);   else pass_cnt++;
            end
            if (k == 22) we0 = 1'b0;
        end
        $display("back_to_back: three 8'hA3 frames checked");
    endtask

    task automatic test_reset_mid();
        logic [9:0] frame;
        data0 = 8'hFF;
        we0   = 1'b1;
        @(negedge clk);
        we0 = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (busy0 !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy0); else pass_cnt++;
        rst0 = 1'b1;
        @(negedge clk);
        total_cnt += 3;
        if (tx0 !== 1'b1)   $display("FAIL mid_rst_tx: got %b want 1", tx0);     else pass_cnt++;
        if (rdy0 !== 1'b1)  $display("FAIL mid_rst_rdy: got %b want 1", rdy0);   else pass_cnt++;
        if (busy0 !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy0); else pass_cnt++;
        we0   = 1'b1;
        data0 = 8'h3C;
        @(negedge clk);
        total_cnt += 2;
        if (busy0 !== 1'b0) $display("FAIL rst_write_busy: got %b want 0", busy0); else pass_cnt++;
        if (tx0 !== 1'b1)   $display("FAIL rst_write_tx: got %b want 1", tx0);     else pass_cnt++;
        rst0  = 1'b0;
        frame = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) we0 = 1'b0;
            total_cnt++;
            if (tx0 !== frame[i]) $display("FAIL mid_frame_bit%0d: got %b want %b", i, tx0, frame[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (busy0 !== 1'b0) $display("FAIL mid_end_busy: got %b want 0", busy0); else pass_cnt++;
        $display("reset_mid: abort and clean restart checked");
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`else
        test_basic();
        test_parity_even();
        test_odd_two_stop();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
